// File: rtl/writeback_unit_pkg.sv
// -----------------------------------------------------------------------------
// writeback_unit_pkg
// Shared encodings for the writeback stage: writeback-source select codes,
// load funct3 codes, FSM state encodings and the latched-instruction record.
// No ports (package).
// -----------------------------------------------------------------------------
package writeback_unit_pkg;

   // Writeback source select
   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_MEM  = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_NONE = 2'b11;

   // Load funct3 codes
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE     = 2'b00;
   localparam logic [1:0] ST_WAIT_MEM = 2'b01;
   localparam logic [1:0] ST_COMMIT   = 2'b10;

   // Instruction fields captured on accept
   typedef struct packed {
      logic [4:0] rd;
      logic [1:0] wb_sel;
      logic [2:0] funct3;
      logic [1:0] addr_lsb;
   } wb_fields_t;

endpackage : writeback_unit_pkg

// File: rtl/writeback_unit_load_align_ext.sv
// -----------------------------------------------------------------------------
// load_align_ext
// Purely combinational load lane select, sign/zero extension and load error
// detection (misaligned half/word or unsupported funct3).
// Ports:
//   rdata    in  32  little-endian memory read word
//   funct3   in  3   load type
//   addr_lsb in  2   byte offset within the word
//   data     out 32  extracted, extended load value (0 when in error)
//   err      out 1   load is misaligned or illegal
// -----------------------------------------------------------------------------
module load_align_ext
   import writeback_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lsb,
   output logic [31:0] data,
   output logic        err
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Byte and halfword lane selection from the byte offset
   always_comb begin
      byte_s = 8'h00;
      case (addr_lsb)
         2'd0:    byte_s = rdata[7:0];
         2'd1:    byte_s = rdata[15:8];
         2'd2:    byte_s = rdata[23:16];
         2'd3:    byte_s = rdata[31:24];
         default: byte_s = 8'h00;
      endcase
      if (addr_lsb[1]) begin
         half_s = rdata[31:16];
      end else begin
         half_s = rdata[15:0];
      end
   end

   // Extension per load type; misaligned or unknown loads report err with data 0
   always_comb begin
      data = 32'h0000_0000;
      err  = 1'b0;
      case (funct3)
         F3_LB:  data = {{24{byte_s[7]}}, byte_s};
         F3_LBU: data = {24'h00_0000, byte_s};
         F3_LH: begin
            if (addr_lsb[0]) begin
               err = 1'b1;
            end else begin
               data = {{16{half_s[15]}}, half_s};
            end
         end
         F3_LHU: begin
            if (addr_lsb[0]) begin
               err = 1'b1;
            end else begin
               data = {16'h0000, half_s};
            end
         end
         F3_LW: begin
            if (addr_lsb != 2'b00) begin
               err = 1'b1;
            end else begin
               data = rdata;
            end
         end
         default: err = 1'b1;
      endcase
   end

endmodule : load_align_ext

// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
// Retire stage: accepts one instruction per cycle, waits for the memory
// response on loads, then commits the register-file write for one cycle.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   upstream handshake
//   in_rd, in_wb_sel, in_funct3, in_addr_lsb, in_alu_result, in_pc_plus4
//                       retiring instruction fields
//   mem_rvalid/mem_rdata data-memory read response
//   rf_we, rf_rd, rf_write_data  register-file write port
//   retire, load_err    per-instruction completion / load error pulses
// All pulse outputs and write data are registered.
// -----------------------------------------------------------------------------
module writeback_unit
   import writeback_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_rd,
   input  logic [1:0]  in_wb_sel,
   input  logic [2:0]  in_funct3,
   input  logic [1:0]  in_addr_lsb,
   input  logic [31:0] in_alu_result,
   input  logic [31:0] in_pc_plus4,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_write_data,
   output logic        retire,
   output logic        load_err
);

   logic [1:0]  state_q, state_d;
   wb_fields_t  fields_q, fields_d;
   logic [31:0] data_q, data_d;
   logic        rf_we_q, rf_we_d;
   logic        retire_q, retire_d;
   logic        load_err_q, load_err_d;

   logic        accept_s;
   logic [31:0] wb_data_s;
   logic [31:0] ld_data_s;
   logic        ld_err_s;

   // Extraction works on the latched load fields, not the live inputs
   load_align_ext u_load_align_ext (
      .rdata    (mem_rdata),
      .funct3   (fields_q.funct3),
      .addr_lsb (fields_q.addr_lsb),
      .data     (ld_data_s),
      .err      (ld_err_s)
   );

   // Handshake and non-load writeback data select
   always_comb begin
      in_ready = (state_q != ST_WAIT_MEM);
      accept_s = in_valid & in_ready;
      wb_data_s = 32'h0000_0000;
      case (in_wb_sel)
         WB_ALU:  wb_data_s = in_alu_result;
         WB_PC4:  wb_data_s = in_pc_plus4;
         default: wb_data_s = 32'h0000_0000;
      endcase
   end

   // Next-state and next-output logic; pulses are computed one cycle ahead
   // so they appear registered during COMMIT
   always_comb begin
      state_d    = state_q;
      fields_d   = fields_q;
      data_d     = data_q;
      rf_we_d    = 1'b0;
      retire_d   = 1'b0;
      load_err_d = 1'b0;
      case (state_q)
         ST_IDLE, ST_COMMIT: begin
            if (accept_s) begin
               fields_d.rd       = in_rd;
               fields_d.wb_sel   = in_wb_sel;
               fields_d.funct3   = in_funct3;
               fields_d.addr_lsb = in_addr_lsb;
               if (in_wb_sel == WB_MEM) begin
                  state_d = ST_WAIT_MEM;
               end else begin
                  state_d  = ST_COMMIT;
                  data_d   = wb_data_s;
                  retire_d = 1'b1;
                  rf_we_d  = (in_rd != 5'd0) && (in_wb_sel != WB_NONE);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_MEM: begin
            if (mem_rvalid) begin
               state_d    = ST_COMMIT;
               data_d     = ld_data_s;
               retire_d   = 1'b1;
               load_err_d = ld_err_s;
               rf_we_d    = (fields_q.rd != 5'd0) && !ld_err_s;
            end else begin
               state_d = ST_WAIT_MEM;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; async reset discards any pending instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         fields_q   <= '0;
         data_q     <= 32'h0000_0000;
         rf_we_q    <= 1'b0;
         retire_q   <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fields_q   <= fields_d;
         data_q     <= data_d;
         rf_we_q    <= rf_we_d;
         retire_q   <= retire_d;
         load_err_q <= load_err_d;
      end
   end

   assign rf_we         = rf_we_q;
   assign retire        = retire_q;
   assign load_err      = load_err_q;
   assign rf_rd         = fields_q.rd;
   assign rf_write_data = data_q;

endmodule : writeback_unit

// File: tb/tb_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_writeback_unit
// Directed plus randomized checks of writeback_unit against a behavioural
// load/writeback model.
// -----------------------------------------------------------------------------
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_rd = 5'd0;
   logic [1:0]  in_wb_sel = 2'd0;
   logic [2:0]  in_funct3 = 3'd0;
   logic [1:0]  in_addr_lsb = 2'd0;
   logic [31:0] in_alu_result = 32'h0;
   logic [31:0] in_pc_plus4 = 32'h0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_write_data;
   logic        retire;
   logic        load_err;

   int checks = 0;
   int errors = 0;

   writeback_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_rd         (in_rd),
      .in_wb_sel     (in_wb_sel),
      .in_funct3     (in_funct3),
      .in_addr_lsb   (in_addr_lsb),
      .in_alu_result (in_alu_result),
      .in_pc_plus4   (in_pc_plus4),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata),
      .rf_we         (rf_we),
      .rf_rd         (rf_rd),
      .rf_write_data (rf_write_data),
      .retire        (retire),
      .load_err      (load_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference load semantics: shift the word down by the byte offset, mask,
   // and extend by adding the upper ones when the sign bit is set.
   function automatic void model_load(input logic [2:0] f3, input logic [1:0] lsb,
                                      input logic [31:0] w,
                                      output logic [31:0] d, output bit err);
      logic [31:0] sh;
      logic [31:0] b;
      logic [31:0] h;
      sh  = w >> (8 * lsb);
      b   = sh & 32'd255;
      h   = sh & 32'd65535;
      d   = 32'h0;
      err = 1'b0;
      if (f3 == 3'd0 || f3 == 3'd4) begin
         d = (f3 == 3'd0 && b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      end else if (f3 == 3'd1 || f3 == 3'd5) begin
         if (lsb % 2 == 1) err = 1'b1;
         else d = (f3 == 3'd1 && h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      end else if (f3 == 3'd2) begin
         if (lsb != 2'd0) err = 1'b1;
         else d = w;
      end else begin
         err = 1'b1;
      end
   endfunction

   // One full instruction: accept, optional memory wait, then commit checks.
   // Leaves the unit in COMMIT so the next call is back-to-back.
   task automatic do_txn(input string tag, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [1:0] lsb,
                         input logic [31:0] alu, input logic [31:0] pc,
                         input logic [31:0] w, input int waits);
      logic [31:0] exp_d;
      bit          exp_err;
      bit          exp_we;
      in_valid      = 1'b1;
      in_rd         = rd;
      in_wb_sel     = sel;
      in_funct3     = f3;
      in_addr_lsb   = lsb;
      in_alu_result = alu;
      in_pc_plus4   = pc;
      mem_rvalid    = 1'($urandom % 2);   // must be ignored outside WAIT_MEM
      mem_rdata     = $urandom;
      chk({tag, ".ready"}, {31'd0, in_ready}, 32'd1);
      tick();
      in_valid   = 1'b0;
      mem_rvalid = 1'b0;
      exp_err    = 1'b0;
      if (sel == 2'b01) begin
         for (int i = 0; i < waits; i++) begin
            chk({tag, ".wait_ready"}, {31'd0, in_ready}, 32'd0);
            chk({tag, ".wait_retire"}, {31'd0, retire}, 32'd0);
            chk({tag, ".wait_we"}, {31'd0, rf_we}, 32'd0);
            tick();
         end
         mem_rvalid = 1'b1;
         mem_rdata  = w;
         tick();
         mem_rvalid = 1'b0;
         model_load(f3, lsb, w, exp_d, exp_err);
      end else if (sel == 2'b00) begin
         exp_d = alu;
      end else if (sel == 2'b10) begin
         exp_d = pc;
      end else begin
         exp_d = 32'h0;
      end
      exp_we = (rd != 5'd0) && (sel != 2'b11) && !exp_err;
      chk({tag, ".retire"}, {31'd0, retire}, 32'd1);
      chk({tag, ".we"}, {31'd0, rf_we}, {31'd0, exp_we});
      chk({tag, ".err"}, {31'd0, load_err}, {31'd0, exp_err});
      chk({tag, ".rd"}, {27'd0, rf_rd}, {27'd0, rd});
      if (!exp_err) chk({tag, ".data"}, rf_write_data, exp_d);
   endtask

   task automatic idle_cycle(input string tag);
      in_valid   = 1'b0;
      mem_rvalid = 1'($urandom % 2);
      tick();
      mem_rvalid = 1'b0;
      chk({tag, ".idle_retire"}, {31'd0, retire}, 32'd0);
      chk({tag, ".idle_we"}, {31'd0, rf_we}, 32'd0);
      chk({tag, ".idle_err"}, {31'd0, load_err}, 32'd0);
      chk({tag, ".idle_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst.we", {31'd0, rf_we}, 32'd0);
      chk("rst.retire", {31'd0, retire}, 32'd0);
      chk("rst.err", {31'd0, load_err}, 32'd0);
      chk("rst.rd", {27'd0, rf_rd}, 32'd0);
      chk("rst.data", rf_write_data, 32'h0);
      chk("rst.ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      tick();

      // ALU writeback
      do_txn("alu", 5'd5, 2'b00, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 0);
      idle_cycle("alu");
      // LB sign extension after 3 wait cycles
      do_txn("lb", 5'd7, 2'b01, 3'b000, 2'd2, 32'h0, 32'h0, 32'h0080_FF11, 3);
      chk("lb.value", rf_write_data, 32'hFFFF_FF80);
      idle_cycle("lb");
      // LHU zero extension
      do_txn("lhu", 5'd9, 2'b01, 3'b101, 2'd2, 32'h0, 32'h0, 32'h8001_0000, 1);
      chk("lhu.value", rf_write_data, 32'h0000_8001);
      idle_cycle("lhu");
      // Misaligned LW
      do_txn("lw_mis", 5'd3, 2'b01, 3'b010, 2'd1, 32'h0, 32'h0, 32'h1234_5678, 0);
      chk("lw_mis.err", {31'd0, load_err}, 32'd1);
      idle_cycle("lw_mis");
      // x0 target, then back-to-back ALU and PC+4
      do_txn("x0", 5'd0, 2'b00, 3'd0, 2'd0, 32'h1111_2222, 32'h0, 32'h0, 0);
      do_txn("b2b1", 5'd1, 2'b00, 3'd0, 2'd0, 32'hA5A5_0001, 32'h0, 32'h0, 0);
      do_txn("b2b2", 5'd2, 2'b10, 3'd0, 2'd0, 32'h0, 32'h0000_1004, 32'h0, 0);
      idle_cycle("b2b");

      // Reset mid-load: pending load is dropped, late response ignored
      in_valid    = 1'b1;
      in_rd       = 5'd4;
      in_wb_sel   = 2'b01;
      in_funct3   = 3'b010;
      in_addr_lsb = 2'd0;
      tick();
      in_valid = 1'b0;
      tick();
      chk("rstmid.waiting", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rstmid.ready", {31'd0, in_ready}, 32'd1);
      chk("rstmid.rd", {27'd0, rf_rd}, 32'd0);
      chk("rstmid.data", rf_write_data, 32'h0);
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFE_F00D;
      tick();
      mem_rvalid = 1'b0;
      chk("rstmid.retire", {31'd0, retire}, 32'd0);
      chk("rstmid.we", {31'd0, rf_we}, 32'd0);
      tick();
      chk("rstmid.retire2", {31'd0, retire}, 32'd0);
      chk("rstmid.we2", {31'd0, rf_we}, 32'd0);

      // Randomized instruction stream with occasional idle gaps
      for (int n = 0; n < 80; n++) begin
         do_txn("rnd", 5'($urandom % 32), 2'($urandom % 4), 3'($urandom % 8),
                2'($urandom % 4), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)));
         if ($urandom % 3 == 0) idle_cycle("rnd");
      end
      idle_cycle("end");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_writeback_unit
